// File: rtl/matrix_loader_if.sv
// Handshake and memory write-port bundle between the element source, the loader and matrix_memory.
// The master side is the host stream source; the slave side is the loader itself.
interface matrix_loader_if #(
    parameter int DW = 8,
    parameter int AW = 7
);
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] write_data;
    logic          write_enable;
    logic          read_enable;
    logic          busy;
    logic          done;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, addr, write_data, write_enable, read_enable, busy, done
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, addr, write_data, write_enable, read_enable, busy, done
    );
endinterface

// File: rtl/matrix_loader.sv
// Streams a ROWS x COLS matrix into matrix_memory, then snapshots it and pulses done.
// Define LOADER_TRANSPOSE_EN to store the matrix column-major (transposed B operand).
module matrix_loader #(
    parameter int ROWS = 10,
    parameter int COLS = 10,
    parameter int DW   = 8,
    parameter int AW   = 7
) (
    input  logic            clk,
    input  logic            rst,
    matrix_loader_if.slave  bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
`ifdef LOADER_TRANSPOSE_EN
    localparam logic [AW-1:0] ADDR_STEP = AW'(ROWS);
`else
    localparam logic [AW-1:0] ADDR_STEP = AW'(1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_SNAP,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [AW-1:0] r_runAddr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_writeData;
    logic          r_writeEnable;
    logic          w_beat;
    logic          w_colLast;
    logic          w_rowLast;
    logic          w_lastBeat;
    logic          w_inReady;
    logic          w_busy;
    logic          w_readEnable;
    logic          w_done;

    assign w_beat     = bus.in_valid && (r_state == S_LOAD);
    assign w_colLast  = (r_col == COL_LAST);
    assign w_rowLast  = (r_row == ROW_LAST);
    assign w_lastBeat = w_beat && w_colLast && w_rowLast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_inReady    = 1'b0;
        w_busy       = 1'b1;
        w_readEnable = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_inReady = 1'b1;
                if (w_lastBeat) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_next = S_SNAP;
            end
            S_SNAP: begin
                w_readEnable = 1'b1;
                w_next       = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The running address always holds the address of the next element, so each
    // beat only copies it out and steps it; the counters only detect wrap points.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row         <= '0;
            r_col         <= '0;
            r_runAddr     <= '0;
            r_addr        <= '0;
            r_writeData   <= '0;
            r_writeEnable <= 1'b0;
        end else begin
            r_writeEnable <= w_beat;
            if (w_beat) begin
                r_addr      <= r_runAddr;
                r_writeData <= bus.in_data;
                if (w_colLast) begin
                    r_col <= '0;
                    if (w_rowLast) begin
                        r_row     <= '0;
                        r_runAddr <= '0;
                    end else begin
                        r_row     <= r_row + 1'b1;
`ifdef LOADER_TRANSPOSE_EN
                        r_runAddr <= AW'(r_row) + AW'(1);
`else
                        r_runAddr <= r_runAddr + ADDR_STEP;
`endif
                    end
                end else begin
                    r_col     <= r_col + 1'b1;
                    r_runAddr <= r_runAddr + ADDR_STEP;
                end
            end
        end
    end

    assign bus.in_ready     = w_inReady;
    assign bus.busy         = w_busy;
    assign bus.read_enable  = w_readEnable;
    assign bus.done         = w_done;
    assign bus.addr         = r_addr;
    assign bus.write_data   = r_writeData;
    assign bus.write_enable = r_writeEnable;
endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader with a small matrix_memory model (write port plus snapshot).
// Expected addresses follow the LOADER_TRANSPOSE_EN setting of the build.
module tb_matrix_loader;
    localparam int ROWS = 10;
    localparam int COLS = 10;
    localparam int DW   = 8;
    localparam int AW   = 7;
    localparam int N    = ROWS * COLS;

    logic clk = 1'b0;
    logic rst;
    logic clearMem = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] mem  [0:(1<<AW)-1];
    logic [DW-1:0] snap [0:(1<<AW)-1];
    logic [AW-1:0] addrAt1;
    logic [AW-1:0] addrAt10;
    logic [AW-1:0] addrAt99;

    always #5 clk = ~clk;

    matrix_loader_if #(.DW(DW), .AW(AW)) bus ();

    matrix_loader #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(posedge clk) begin
        if (clearMem) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
        end else if (bus.write_enable) begin
            mem[bus.addr] <= bus.write_data;
        end
        if (bus.read_enable) snap <= mem;
    end

    function automatic int expAddr(input int k);
`ifdef LOADER_TRANSPOSE_EN
        return (k % COLS) * ROWS + (k / COLS);
`else
        return k;
`endif
    endfunction

    function automatic logic [DW-1:0] beatValue(input int mode, input int k);
        logic [31:0] kv;
        kv = k;
        return (mode == 2) ? 8'hA5 : kv[DW-1:0];
    endfunction

    task automatic clear_memory();
        @(negedge clk);
        clearMem = 1'b1;
        @(negedge clk);
        clearMem = 1'b0;
    endtask

    // mode 0: value k back-to-back, 1: value k with random bubbles, 2: constant 0xA5.
    // Offsets are counted in cycles after the cycle holding the last beat.
    task automatic drive_load(input int mode, input bit doStart, input int startAt,
                              output int nWrites, output int nBad,
                              output int reOff, output int doneOff);
        int k;
        int cyc;
        bit valid;
        nWrites = 0; nBad = 0; reOff = -1; doneOff = -1; k = 0; cyc = 0;
        @(negedge clk);
        if (doStart) begin
            bus.start = 1'b1; bus.in_valid = 1'b0;
            @(negedge clk);
            bus.start = 1'b0;
        end
        while (k < N && cyc < 1000) begin
            valid = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.in_valid = valid;
            bus.in_data  = beatValue(mode, k);
            bus.start    = (k == startAt);
            if (bus.in_ready !== 1'b1) nBad++;
            @(posedge clk); #1;
            cyc++;
            if (bus.write_enable !== valid) nBad++;
            if (bus.read_enable !== 1'b0 || bus.done !== 1'b0) nBad++;
            if (valid) begin
                if (bus.addr !== AW'(expAddr(k)) || bus.write_data !== beatValue(mode, k)) nBad++;
                if (k == 1)  addrAt1  = bus.addr;
                if (k == 10) addrAt10 = bus.addr;
                if (k == 99) addrAt99 = bus.addr;
                nWrites++;
                k++;
                if (k == N && bus.in_ready !== 1'b0) nBad++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        for (int t = 2; t <= 6; t++) begin
            @(posedge clk); #1;
            if (bus.write_enable !== 1'b0) nBad++;
            if (bus.read_enable === 1'b1) begin
                if (reOff < 0) reOff = t; else nBad++;
            end
            if (bus.done === 1'b1) begin
                if (doneOff < 0) doneOff = t; else nBad++;
            end
            if (t >= 4 && bus.busy !== 1'b0) nBad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_enable: got %b expected 0", bus.write_enable); end
        checks++; if (bus.read_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_enable: got %b expected 0", bus.read_enable); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.addr !== 7'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", bus.addr); end
        checks++; if (bus.write_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_write_data: got %0d expected 0", bus.write_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nWrites, nBad, reOff, doneOff;
        logic [AW-1:0] exp1, exp10, exp99;
        clear_memory();
        drive_load(0, 1'b1, -1, nWrites, nBad, reOff, doneOff);
`ifdef LOADER_TRANSPOSE_EN
        exp1 = 7'd10; exp10 = 7'd1; exp99 = 7'd99;
`else
        exp1 = 7'd1; exp10 = 7'd10; exp99 = 7'd99;
`endif
        checks++; if (nWrites !== 100) begin errors++; $display("[TB] FAIL b2b_writes: got %0d expected 100", nWrites); end
        checks++; if (nBad !== 0) begin errors++; $display("[TB] FAIL b2b_bus_errors: got %0d expected 0", nBad); end
        checks++; if (reOff !== 2) begin errors++; $display("[TB] FAIL b2b_read_enable_offset: got %0d expected 2", reOff); end
        checks++; if (doneOff !== 3) begin errors++; $display("[TB] FAIL b2b_done_offset: got %0d expected 3", doneOff); end
        checks++; if (addrAt1 !== exp1) begin errors++; $display("[TB] FAIL b2b_addr_beat1: got %0d expected %0d", addrAt1, exp1); end
        checks++; if (addrAt10 !== exp10) begin errors++; $display("[TB] FAIL b2b_addr_beat10: got %0d expected %0d", addrAt10, exp10); end
        checks++; if (addrAt99 !== exp99) begin errors++; $display("[TB] FAIL b2b_addr_beat99: got %0d expected %0d", addrAt99, exp99); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (snap[expAddr(k)] !== beatValue(0, k)) begin
                errors++;
                $display("[TB] FAIL b2b_snapshot[%0d]: got %0d expected %0d", k, snap[expAddr(k)], beatValue(0, k));
            end
        end
    endtask

    task automatic test_bubbles();
        int nWrites, nBad, reOff, doneOff;
        clear_memory();
        drive_load(1, 1'b1, -1, nWrites, nBad, reOff, doneOff);
        checks++; if (nWrites !== 100) begin errors++; $display("[TB] FAIL bubble_writes: got %0d expected 100", nWrites); end
        checks++; if (nBad !== 0) begin errors++; $display("[TB] FAIL bubble_bus_errors: got %0d expected 0", nBad); end
        checks++; if (reOff !== 2) begin errors++; $display("[TB] FAIL bubble_read_enable_offset: got %0d expected 2", reOff); end
        checks++; if (doneOff !== 3) begin errors++; $display("[TB] FAIL bubble_done_offset: got %0d expected 3", doneOff); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (snap[expAddr(k)] !== beatValue(1, k)) begin
                errors++;
                $display("[TB] FAIL bubble_snapshot[%0d]: got %0d expected %0d", k, snap[expAddr(k)], beatValue(1, k));
            end
        end
    endtask

    task automatic test_idle_and_start();
        int nWrites, nBad, reOff, doneOff;
        clear_memory();
        bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("[TB] FAIL idle_write_enable: got %b expected 0", bus.write_enable); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_in_ready: got %b expected 0", bus.in_ready); end
        end
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("[TB] FAIL start_with_valid_write: got %b expected 0", bus.write_enable); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL start_with_valid_busy: got %b expected 1", bus.busy); end
        bus.start = 1'b0;
        drive_load(0, 1'b0, 20, nWrites, nBad, reOff, doneOff);
        checks++; if (nWrites !== 100) begin errors++; $display("[TB] FAIL restart_writes: got %0d expected 100", nWrites); end
        checks++; if (nBad !== 0) begin errors++; $display("[TB] FAIL restart_bus_errors: got %0d expected 0", nBad); end
        checks++; if (reOff !== 2) begin errors++; $display("[TB] FAIL restart_read_enable_offset: got %0d expected 2", reOff); end
        checks++; if (doneOff !== 3) begin errors++; $display("[TB] FAIL restart_done_offset: got %0d expected 3", doneOff); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (snap[expAddr(k)] !== beatValue(0, k)) begin
                errors++;
                $display("[TB] FAIL restart_snapshot[%0d]: got %0d expected %0d", k, snap[expAddr(k)], beatValue(0, k));
            end
        end
    endtask

    task automatic test_reset_mid();
        int nWrites, nBad, reOff, doneOff, pulses;
        @(negedge clk);
        bus.start = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 37; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = beatValue(0, k);
            @(negedge clk);
        end
        rst = 1'b1; bus.in_data = beatValue(0, 37);
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("[TB] FAIL midrst_write_enable: got %b expected 0", bus.write_enable); end
        checks++; if (bus.addr !== 7'd0) begin errors++; $display("[TB] FAIL midrst_addr: got %0d expected 0", bus.addr); end
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.read_enable !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL midrst_stray_activity: got %0d cycles expected 0", pulses); end
        drive_load(2, 1'b1, -1, nWrites, nBad, reOff, doneOff);
        checks++; if (nWrites !== 100) begin errors++; $display("[TB] FAIL reload_writes: got %0d expected 100", nWrites); end
        checks++; if (nBad !== 0) begin errors++; $display("[TB] FAIL reload_bus_errors: got %0d expected 0", nBad); end
        checks++; if (doneOff !== 3) begin errors++; $display("[TB] FAIL reload_done_offset: got %0d expected 3", doneOff); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (snap[k] !== 8'hA5) begin
                errors++;
                $display("[TB] FAIL reload_snapshot[%0d]: got %0h expected a5", k, snap[k]);
            end
        end
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_idle_and_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
